// File: rtl/ifetch_unit.sv
// ifetch_unit -- RV32 instruction-fetch stage.
//
// Holds the fetch PC, issues in-order word requests to instruction memory over
// a valid/ready port, and buffers returned words together with their PC in a
// small FIFO that serves as the IF/ID register. Decode back-pressures with
// stall_i; execute redirects the PC with redirect_i/redirect_pc_i, which
// discards every buffered word and every response still in flight.
//
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN
//   defined   : a redirect target with nonzero bits [1:0] sets misalign_o
//               (sticky until rst) and stops all further requests.
//   undefined : misalign_o is tied 0 and the low target bits are cleared.
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   imem_req_*       request channel: valid/ready handshake, word address
//   imem_rsp_*       response channel: in-order instruction words
//   redirect_i/_pc_i PC redirect from execute
//   stall_i          decode not consuming this cycle
//   id_valid_o/id_pc_o/id_inst_o  presented instruction (NOP when invalid)
//   misalign_o       misaligned redirect flag (macro build only)

module ifetch_unit #(
  parameter int unsigned       XLEN       = 32,
  parameter logic [XLEN-1:0]   RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [31:0]     id_inst_o,
  output logic            misalign_o
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam logic [CW:0] DEPTH_S = FIFO_DEPTH[CW:0];
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;      // PC belonging to the next response to keep
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            misalign;

  logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
  logic [31:0]     fifo_inst [FIFO_DEPTH];

  logic            accept;
  logic            push;
  logic            pop;
  logic            run_n;
  logic            mis_n;
  logic            req_valid_n;
  logic [XLEN-1:0] req_addr_n;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] pc_n;
  logic [CW-1:0]   out_n;
  logic [CW-1:0]   cnt_n;
  logic [CW-1:0]   drop_n;
  logic [CW:0]     sum_n;

  always_comb begin
    accept   = req_valid & imem_req_ready;
    push     = imem_rsp_valid & (state == RUN) & ~redirect_i;
    pop      = (count != '0) & ~stall_i & ~redirect_i;
    redir_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

`ifdef IFETCH_MISALIGN_TRAP_EN
    mis_n = misalign | (redirect_i & (redirect_pc_i[1:0] != 2'b00));
`else
    mis_n = 1'b0;
`endif

    // A request accepted in the redirect cycle is still outstanding and
    // must be dropped; a response arriving in that cycle is discarded now.
    out_n = outstanding + CW'(accept) - CW'(imem_rsp_valid);
    cnt_n = redirect_i ? '0 : count + CW'(push) - CW'(pop);

    drop_n = drop;
    if (redirect_i)
      drop_n = out_n;
    else if ((state == FLUSH) && imem_rsp_valid && (drop != '0))
      drop_n = drop - CW'(1);

    pc_n = pc;
    if (redirect_i)
      pc_n = redir_pc;
    else if (accept)
      pc_n = pc + XLEN'(4);

    // BOOT and RUN never carry a drop count, so the next state is RUN
    // exactly when nothing remains to be discarded.
    run_n = (drop_n == '0);
    sum_n = {1'b0, out_n} + {1'b0, cnt_n};

    req_valid_n = 1'b0;
    req_addr_n  = req_addr;
    if (req_valid && !imem_req_ready && !redirect_i) begin
      req_valid_n = 1'b1;
    end else if (run_n && !mis_n && (sum_n < DEPTH_S)) begin
      req_valid_n = 1'b1;
      req_addr_n  = pc_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      req_valid   <= 1'b0;
      req_addr    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      misalign    <= 1'b0;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (redirect_i && !run_n) state <= FLUSH;
        FLUSH:   if (run_n) state <= RUN;
        default: state <= BOOT;
      endcase

      pc          <= pc_n;
      req_valid   <= req_valid_n;
      req_addr    <= req_addr_n;
      outstanding <= out_n;
      drop        <= drop_n;
      count       <= cnt_n;
      misalign    <= mis_n;

      if (redirect_i)
        rsp_pc <= redir_pc;
      else if (push)
        rsp_pc <= rsp_pc + XLEN'(4);

      if (redirect_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end

      // Buffer space is reserved when a request issues.
      if (push)
        assert (count != FIFO_DEPTH[CW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= rsp_pc;
      fifo_inst[wr_ptr] <= imem_rsp_data;
    end
  end

  logic unused_lsb;
  assign unused_lsb = ^redirect_pc_i[1:0];

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = req_addr;
  assign id_valid_o     = (count != '0);
  assign id_pc_o        = id_valid_o ? fifo_pc[rd_ptr] : '0;
  assign id_inst_o      = id_valid_o ? fifo_inst[rd_ptr] : NOP;
  assign misalign_o     = misalign;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit with a fixed-latency memory model.
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        misalign_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lat   = 1;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] acc_addr[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];

  ifetch_unit #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .stall_i(stall_i),
    .id_valid_o(id_valid_o),
    .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  // Memory model and decode-side monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      imem_rsp_valid = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = inst_of(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + lat);
        acc_addr.push_back(imem_req_addr);
      end
      if (id_valid_o && !stall_i && !redirect_i) begin
        got_pc.push_back(id_pc_o);
        got_inst.push_back(id_inst_o);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_addr.delete();
    got_pc.delete();
    got_inst.delete();
  endtask

  // Returns in the BOOT cycle right after the last reset edge.
  task automatic do_reset();
    rst            = 1'b1;
    redirect_i     = 1'b0;
    redirect_pc_i  = '0;
    stall_i        = 1'b0;
    imem_req_ready = 1'b1;
    step();
    step();
    clear_logs();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (8) step();
    rst = 1'b1;
    step();
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    tests++; if (id_valid_o !== 1'b0) begin fails++; $display("FAIL rst_id_valid got=%b exp=0", id_valid_o); end
    tests++; if (id_pc_o !== 32'h0) begin fails++; $display("FAIL rst_id_pc got=%h exp=0", id_pc_o); end
    tests++; if (id_inst_o !== NOP) begin fails++; $display("FAIL rst_id_inst got=%h exp=%h", id_inst_o, NOP); end
    tests++; if (misalign_o !== 1'b0) begin fails++; $display("FAIL rst_misalign got=%b exp=0", misalign_o); end
    rst = 1'b0;
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL boot_req_valid got=%b exp=0", imem_req_valid); end
  endtask

  task automatic test_basic();
    lat = 1;
    do_reset();
    step();
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL first_req got=%b/%h exp=1/00000000", imem_req_valid, imem_req_addr); end
    step();
    tests++; if (id_valid_o !== 1'b0) begin fails++; $display("FAIL lat_cycle2 got=%b exp=0", id_valid_o); end
    step();
    tests++; if (id_valid_o !== 1'b1) begin fails++; $display("FAIL lat_cycle3 got=%b exp=1", id_valid_o); end
    tests++; if (id_pc_o !== 32'h0 || id_inst_o !== inst_of(32'h0)) begin fails++; $display("FAIL first_inst got=%h/%h exp=00000000/%h", id_pc_o, id_inst_o, inst_of(32'h0)); end
    repeat (20) step();
    tests++; if (got_pc.size() < 6) begin fails++; $display("FAIL basic_count got=%0d exp>=6", got_pc.size()); end
    for (int k = 0; k < got_pc.size(); k++) begin
      tests++; if (got_pc[k] !== 32'(4 * k) || got_inst[k] !== inst_of(32'(4 * k))) begin fails++; $display("FAIL basic_seq[%0d] got=%h/%h exp=%h/%h", k, got_pc[k], got_inst[k], 32'(4 * k), inst_of(32'(4 * k))); end
    end
    for (int k = 0; k < acc_addr.size(); k++) begin
      tests++; if (acc_addr[k] !== 32'(4 * k)) begin fails++; $display("FAIL basic_addr[%0d] got=%h exp=%h", k, acc_addr[k], 32'(4 * k)); end
    end
  endtask

  task automatic test_stall();
    int n;
    int waited;
    lat = 1;
    do_reset();
    waited = 0;
    while (id_valid_o !== 1'b1 && waited < 20) begin step(); waited++; end
    tests++; if (id_valid_o !== 1'b1) begin fails++; $display("FAIL stall_wait got=%b exp=1", id_valid_o); end
    stall_i = 1'b1;
    n = got_pc.size();
    for (int c = 0; c < 5; c++) begin
      tests++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'(4 * n) || id_inst_o !== inst_of(32'(4 * n))) begin fails++; $display("FAIL stall_hold[%0d] got=%b/%h/%h exp=1/%h/%h", c, id_valid_o, id_pc_o, id_inst_o, 32'(4 * n), inst_of(32'(4 * n))); end
      tests++; if (acc_addr.size() - got_pc.size() > 2) begin fails++; $display("FAIL stall_backlog[%0d] got=%0d exp<=2", c, acc_addr.size() - got_pc.size()); end
      step();
    end
    stall_i = 1'b0;
    repeat (20) step();
    tests++; if (got_pc.size() < n + 5) begin fails++; $display("FAIL stall_resume got=%0d exp>=%0d", got_pc.size(), n + 5); end
    for (int k = 0; k < got_pc.size(); k++) begin
      tests++; if (got_pc[k] !== 32'(4 * k) || got_inst[k] !== inst_of(32'(4 * k))) begin fails++; $display("FAIL stall_seq[%0d] got=%h exp=%h", k, got_pc[k], 32'(4 * k)); end
    end
  endtask

  task automatic test_ready_low();
    int n;
    int waited;
    lat = 1;
    do_reset();
    repeat (4) step();
    waited = 0;
    while (imem_req_valid !== 1'b1 && waited < 20) begin step(); waited++; end
    imem_req_ready = 1'b0;
    n = acc_addr.size();
    for (int c = 0; c < 3; c++) begin
      step();
      tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * n)) begin fails++; $display("FAIL rdy_hold[%0d] got=%b/%h exp=1/%h", c, imem_req_valid, imem_req_addr, 32'(4 * n)); end
    end
    tests++; if (acc_addr.size() != n) begin fails++; $display("FAIL rdy_noaccept got=%0d exp=%0d", acc_addr.size(), n); end
    imem_req_ready = 1'b1;
    repeat (20) step();
    tests++; if (acc_addr.size() < n + 5) begin fails++; $display("FAIL rdy_resume got=%0d exp>=%0d", acc_addr.size(), n + 5); end
    for (int k = 0; k < acc_addr.size(); k++) begin
      tests++; if (acc_addr[k] !== 32'(4 * k)) begin fails++; $display("FAIL rdy_addr[%0d] got=%h exp=%h", k, acc_addr[k], 32'(4 * k)); end
    end
    for (int k = 0; k < got_pc.size(); k++) begin
      tests++; if (got_pc[k] !== 32'(4 * k)) begin fails++; $display("FAIL rdy_seq[%0d] got=%h exp=%h", k, got_pc[k], 32'(4 * k)); end
    end
  endtask

  task automatic test_redirect();
    int waited;
    lat = 3;
    do_reset();
    waited = 0;
    while (mq_addr.size() != 2 && waited < 20) begin step(); waited++; end
    tests++; if (mq_addr.size() != 2) begin fails++; $display("FAIL redir_inflight got=%0d exp=2", mq_addr.size()); end
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    step();
    redirect_i = 1'b0;
    tests++; if (id_valid_o !== 1'b0) begin fails++; $display("FAIL redir_id_valid got=%b exp=0", id_valid_o); end
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL redir_flush_req got=%b exp=0", imem_req_valid); end
    clear_logs();
    repeat (30) step();
    tests++; if (got_pc.size() < 2 || acc_addr.size() < 2) begin fails++; $display("FAIL redir_count got=%0d/%0d exp>=2", got_pc.size(), acc_addr.size()); end
    tests++; if (acc_addr[0] !== 32'h100) begin fails++; $display("FAIL redir_first_addr got=%h exp=00000100", acc_addr[0]); end
    for (int k = 0; k < got_pc.size(); k++) begin
      tests++; if (got_pc[k] !== 32'h100 + 32'(4 * k) || got_inst[k] !== inst_of(32'h100 + 32'(4 * k))) begin fails++; $display("FAIL redir_seq[%0d] got=%h/%h exp=%h/%h", k, got_pc[k], got_inst[k], 32'h100 + 32'(4 * k), inst_of(32'h100 + 32'(4 * k))); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hFFFF_FFF8;
    exp_a[1] = 32'hFFFF_FFFC;
    exp_a[2] = 32'h0000_0000;
    exp_a[3] = 32'h0000_0004;
    lat = 1;
    do_reset();
    repeat (6) step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    step();
    redirect_i = 1'b0;
    clear_logs();
    repeat (20) step();
    tests++; if (acc_addr.size() < 4 || got_pc.size() < 4) begin fails++; $display("FAIL wrap_count got=%0d/%0d exp>=4", acc_addr.size(), got_pc.size()); end
    for (int k = 0; k < 4; k++) begin
      tests++; if (acc_addr[k] !== exp_a[k]) begin fails++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", k, acc_addr[k], exp_a[k]); end
      tests++; if (got_pc[k] !== exp_a[k]) begin fails++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", k, got_pc[k], exp_a[k]); end
    end
  endtask

  task automatic test_misalign();
    lat = 1;
    do_reset();
    repeat (6) step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0102;
    step();
    redirect_i = 1'b0;
    clear_logs();
`ifdef IFETCH_MISALIGN_TRAP_EN
    for (int c = 0; c < 10; c++) begin
      step();
      tests++; if (misalign_o !== 1'b1 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL mis_trap[%0d] got=%b/%b exp=1/0", c, misalign_o, imem_req_valid); end
    end
    tests++; if (acc_addr.size() != 0) begin fails++; $display("FAIL mis_noreq got=%0d exp=0", acc_addr.size()); end
`else
    repeat (15) step();
    tests++; if (misalign_o !== 1'b0) begin fails++; $display("FAIL mis_flag got=%b exp=0", misalign_o); end
    tests++; if (acc_addr.size() < 2 || got_pc.size() < 2) begin fails++; $display("FAIL mis_count got=%0d/%0d exp>=2", acc_addr.size(), got_pc.size()); end
    tests++; if (acc_addr[0] !== 32'h100) begin fails++; $display("FAIL mis_addr got=%h exp=00000100", acc_addr[0]); end
    tests++; if (got_pc[0] !== 32'h100 || got_pc[1] !== 32'h104) begin fails++; $display("FAIL mis_pc got=%h,%h exp=00000100,00000104", got_pc[0], got_pc[1]); end
`endif
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_i     = 1'b0;
    redirect_pc_i  = '0;
    stall_i        = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_ready_low();
    test_redirect();
    test_wrap();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
